// File: rtl/shadow_latch_pkg.sv
// Shared mode encoding for the shadow latch bank and its per-channel cells.
package shadow_latch_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_DIRECT = 2'd0,
        MODE_SHADOW = 2'd1,
        MODE_FREEZE = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    // True when writes and commits are honoured; reserved decodes like FREEZE.
    function automatic logic mode_live(input mode_e m);
        return (m == MODE_DIRECT) || (m == MODE_SHADOW);
    endfunction

endpackage

// File: rtl/shadow_latch_cell.sv
// One channel: shadow, active and pending registers with direct/shadow/freeze update rules.
module shadow_latch_cell
    import shadow_latch_pkg::*;
#(
    parameter int unsigned       WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              commit,
    input  logic              clear,
    output logic [WIDTH-1:0]  act,
    output logic              pending,
    output logic              upd_c
);

    mode_e            mode_q;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] act_d;
    logic [WIDTH-1:0] shadow_d;
    logic             pending_d;

    assign mode_q = mode_e'(mode);

    // Next-state for this channel; a same-cycle write always wins over stale shadow data.
    always_comb begin
        act_d     = act;
        shadow_d  = shadow;
        pending_d = pending;
        upd_c     = 1'b0;
        if (clear) begin
            act_d     = RST_VAL;
            shadow_d  = RST_VAL;
            pending_d = 1'b0;
        end else begin
            unique case (mode_q)
                MODE_DIRECT: begin
                    upd_c = commit && pending;
                    if (wr_en) begin
                        act_d = wr_data;
                    end else if (commit && pending) begin
                        act_d = shadow;
                    end
                    if (wr_en || commit) begin
                        pending_d = 1'b0;
                    end
                end
                MODE_SHADOW: begin
                    upd_c = commit && (pending || wr_en);
                    if (wr_en) begin
                        shadow_d = wr_data;
                    end
                    if (commit) begin
                        if (wr_en) begin
                            act_d = wr_data;
                        end else if (pending) begin
                            act_d = shadow;
                        end
                        pending_d = 1'b0;
                    end else if (wr_en) begin
                        pending_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act     <= RST_VAL;
            shadow  <= RST_VAL;
            pending <= 1'b0;
        end else begin
            act     <= act_d;
            shadow  <= shadow_d;
            pending <= pending_d;
        end
    end

endmodule

// File: rtl/shadow_latch_bank.sv
// Bank of NCH shadowed channels with an atomic commit strobe, ack pulse and commit counter.
module shadow_latch_bank
    import shadow_latch_pkg::*;
#(
    parameter int unsigned       WIDTH   = 8,
    parameter int unsigned       NCH     = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0,
    parameter int unsigned       CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [MODE_W-1:0]      mode,
    input  logic [NCH-1:0]         wr_en,
    input  logic [NCH*WIDTH-1:0]   wr_data,
    input  logic                   commit,
    input  logic                   clear,
    output logic [NCH*WIDTH-1:0]   act_out,
    output logic [NCH-1:0]         pending,
    output logic                   commit_ack,
    output logic [CNT_W-1:0]       commit_cnt
);

    logic [NCH-1:0] upd_c;
    logic           ack_c;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        shadow_latch_cell #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .mode    (mode),
            .wr_en   (wr_en[i]),
            .wr_data (wr_data[i*WIDTH +: WIDTH]),
            .commit  (commit),
            .clear   (clear),
            .act     (act_out[i*WIDTH +: WIDTH]),
            .pending (pending[i]),
            .upd_c   (upd_c[i])
        );
    end

    // Ack only when the commit actually moved data into at least one channel.
    assign ack_c = !clear && (|upd_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_ack <= 1'b0;
            commit_cnt <= '0;
        end else begin
            commit_ack <= ack_c;
            if (ack_c) begin
                commit_cnt <= commit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shadow_latch_bank.sv
// Directed self-checking bench for shadow_latch_bank (WIDTH=8, NCH=4, CNT_W=2).
module tb_shadow_latch_bank;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 2;

    logic                 clk;
    logic                 rst_n;
    logic [1:0]           mode;
    logic [NCH-1:0]       wr_en;
    logic [NCH*WIDTH-1:0] wr_data;
    logic                 commit;
    logic                 clear;
    logic [NCH*WIDTH-1:0] act_out;
    logic [NCH-1:0]       pending;
    logic                 commit_ack;
    logic [CNT_W-1:0]     commit_cnt;

    int checks = 0;
    int passes = 0;

    shadow_latch_bank #(
        .WIDTH   (WIDTH),
        .NCH     (NCH),
        .RST_VAL (8'h00),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .commit     (commit),
        .clear      (clear),
        .act_out    (act_out),
        .pending    (pending),
        .commit_ack (commit_ack),
        .commit_cnt (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_act, input logic [3:0] e_pend,
                           input logic e_ack, input logic [1:0] e_cnt);
        chk({tag, ".act"}, act_out, e_act);
        chk({tag, ".pend"}, 32'(pending), 32'(e_pend));
        chk({tag, ".ack"}, 32'(commit_ack), 32'(e_ack));
        chk({tag, ".cnt"}, 32'(commit_cnt), 32'(e_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] m, input logic [3:0] we, input logic [31:0] d,
                         input logic c, input logic clr);
        mode    = m;
        wr_en   = we;
        wr_data = d;
        commit  = c;
        clear   = clr;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(2'd0, 4'h0, 32'h0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        drive(2'($urandom), 4'($urandom), $urandom, 1'b1, 1'b0);
        #1;
        chk_all("reset_async", 32'h0, 4'h0, 1'b0, 2'd0);
        @(negedge clk);
        chk_all("reset_held", 32'h0, 4'h0, 1'b0, 2'd0);
        rst_n = 1'b1;

        drive(2'd0, 4'b0100, 32'h00A5_0000, 1'b0, 1'b0);
        step();
        chk_all("direct_wr", 32'h00A5_0000, 4'h0, 1'b0, 2'd0);

        drive(2'd1, 4'b1001, 32'h3355_6611, 1'b0, 1'b0);
        step();
        chk_all("shadow_wr", 32'h00A5_0000, 4'b1001, 1'b0, 2'd0);

        drive(2'd1, 4'b0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step();
        chk_all("commit1", 32'h33A5_0011, 4'h0, 1'b1, 2'd1);

        drive(2'd1, 4'b0000, 32'h0, 1'b0, 1'b0);
        step();
        chk_all("ack_one_cycle", 32'h33A5_0011, 4'h0, 1'b0, 2'd1);

        drive(2'd1, 4'b0000, 32'h0, 1'b1, 1'b0);
        step();
        chk_all("empty_commit", 32'h33A5_0011, 4'h0, 1'b0, 2'd1);

        drive(2'd1, 4'b0010, 32'h0000_7E00, 1'b1, 1'b0);
        step();
        chk_all("forward", 32'h33A5_7E11, 4'h0, 1'b1, 2'd2);

        drive(2'd1, 4'b0010, 32'h0000_4200, 1'b0, 1'b0);
        step();
        chk_all("shadow_ch1", 32'h33A5_7E11, 4'b0010, 1'b0, 2'd2);

        drive(2'd2, 4'b1111, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step();
        chk_all("freeze", 32'h33A5_7E11, 4'b0010, 1'b0, 2'd2);

        drive(2'd3, 4'b1111, 32'hEEEE_EEEE, 1'b1, 1'b0);
        step();
        chk_all("reserved", 32'h33A5_7E11, 4'b0010, 1'b0, 2'd2);

        drive(2'd1, 4'b0000, 32'h0, 1'b1, 1'b0);
        step();
        chk_all("post_freeze_commit", 32'h33A5_4211, 4'h0, 1'b1, 2'd3);

        drive(2'd1, 4'b0001, 32'h0000_0099, 1'b0, 1'b0);
        step();
        chk_all("shadow_ch0", 32'h33A5_4211, 4'b0001, 1'b0, 2'd3);

        drive(2'd0, 4'b0000, 32'h0, 1'b1, 1'b0);
        step();
        chk_all("direct_commit_wrap", 32'h33A5_4299, 4'h0, 1'b1, 2'd0);

        drive(2'd1, 4'b1000, 32'hBB00_0000, 1'b1, 1'b0);
        step();
        chk_all("forward_ch3", 32'hBBA5_4299, 4'h0, 1'b1, 2'd1);

        drive(2'd1, 4'b0100, 32'h00CC_0000, 1'b0, 1'b0);
        step();
        chk_all("shadow_ch2", 32'hBBA5_4299, 4'b0100, 1'b0, 2'd1);

        drive(2'd1, 4'b0001, 32'h0000_0077, 1'b1, 1'b1);
        step();
        chk_all("clear_commit", 32'h0, 4'h0, 1'b0, 2'd1);

        drive(2'd1, 4'b0000, 32'h0, 1'b1, 1'b0);
        step();
        chk_all("commit_after_clear", 32'h0, 4'h0, 1'b0, 2'd1);

        drive(2'd1, 4'b0010, 32'h0000_7700, 1'b0, 1'b0);
        step();
        chk_all("shadow_pre_direct", 32'h0, 4'b0010, 1'b0, 2'd1);

        drive(2'd0, 4'b0010, 32'h0000_1200, 1'b0, 1'b0);
        step();
        chk_all("direct_clears_pend", 32'h0000_1200, 4'h0, 1'b0, 2'd1);

        drive(2'd1, 4'b0010, 32'h0000_5500, 1'b0, 1'b0);
        step();
        chk_all("pre_abort", 32'h0000_1200, 4'b0010, 1'b0, 2'd1);

        drive(2'd1, 4'b0000, 32'h0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("abort_async", 32'h0, 4'h0, 1'b0, 2'd0);
        step();
        chk_all("abort_held", 32'h0, 4'h0, 1'b0, 2'd0);
        rst_n = 1'b1;
        drive(2'd0, 4'b1000, 32'h5A00_0000, 1'b0, 1'b0);
        step();
        chk_all("first_edge", 32'h5A00_0000, 4'h0, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
